// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper for the UART receive path.
package uart_pkg;

    localparam int BAUD_START  = 1;
    localparam int BAUD_DATA   = 8;
    localparam int BAUD_PARITY = 1;
    localparam int BAUD_STOP   = 2;
    localparam int FRAME_BAUDS = BAUD_START + BAUD_DATA + BAUD_PARITY + BAUD_STOP;

    // Tick-count values at which the deframer changes phase.
    localparam logic [3:0] DATA_LAST_TICK  = 4'(BAUD_START + BAUD_DATA - 1);
    localparam logic [3:0] FRAME_LAST_TICK = 4'(FRAME_BAUDS - 1);

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t DATA   = 3'd1;
    localparam state_t PARITY = 3'd2;
    localparam state_t STOP1  = 3'd3;
    localparam state_t STOP2  = 3'd4;
    localparam state_t DONE   = 3'd5;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Byte-side bundle of the UART deframer: serial input, baud pulse, holding-register handshake.
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic       rx;
    logic       baud_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    state_t     fsm_state;

    // rx_valid/rx_ready: a byte transfers on every cycle where both are high; while
    // rx_valid is high, rx_data and the error flags hold steady, and rx_valid never drops
    // without a transfer.
    modport slave (
        input  rx, baud_tick, rx_ready,
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy, fsm_state
    );

    modport master (
        output rx, baud_tick, rx_ready,
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy, fsm_state
    );

endinterface

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for asynchronous Rx-side inputs; resets to the idle-high level.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: samples 12 bit-centre ticks per frame, checks start/parity/stop,
// and hands the byte plus error flags to the packet layer through a one-entry holding register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic            ref_clk,
    input logic            reset,
    uart_rx_frame_if.slave bus
);

    logic       rx_s;
    state_t     state;
    logic [3:0] tick_cnt;
    logic [7:0] shift_reg;
    logic       start_bit;
    logic       par_bit;
    logic       stop1_bit;
    logic       stop2_bit;

    logic [7:0] data_q;
    logic       valid_q;
    logic       parity_err_q;
    logic       frame_err_q;
    logic       overrun_q;
    logic       can_load;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .ref_clk (ref_clk),
        .reset   (reset),
        .d       (bus.rx),
        .q       (rx_s)
    );

    // The tick counter free-runs on baud ticks so a bad start bit never breaks alignment.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            tick_cnt  <= 4'd0;
            state     <= IDLE;
            shift_reg <= 8'd0;
            start_bit <= 1'b0;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b0;
            stop2_bit <= 1'b0;
        end else begin
            if (bus.baud_tick) begin
                tick_cnt <= (tick_cnt == FRAME_LAST_TICK) ? 4'd0 : tick_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.baud_tick) begin
                        start_bit <= rx_s;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.baud_tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (tick_cnt == DATA_LAST_TICK) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bus.baud_tick) begin
                        par_bit <= rx_s;
                        state   <= STOP1;
                    end
                end
                STOP1: begin
                    if (bus.baud_tick) begin
                        stop1_bit <= rx_s;
                        state     <= STOP2;
                    end
                end
                STOP2: begin
                    if (bus.baud_tick) begin
                        stop2_bit <= rx_s;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A full register that is being drained in the DONE cycle still accepts the new frame.
    assign can_load = !valid_q || bus.rx_ready;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            data_q       <= 8'd0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (state == DONE) begin
            if (can_load) begin
                data_q       <= shift_reg;
                valid_q      <= 1'b1;
                parity_err_q <= par_bit != calc_parity(shift_reg, PARITY_ODD);
                frame_err_q  <= start_bit | ~stop1_bit | ~stop2_bit;
                overrun_q    <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && bus.rx_ready) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state == DATA) || (state == PARITY) ||
                            (state == STOP1) || (state == STOP2);
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames from the test plan, then random frames with a
// random consumer, all checked each cycle against a frame-level model.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam bit PARITY_ODD  = 1'b0;
    localparam int SYNC_STAGES = 2;

    // ---------------- clock / reset ----------------
    logic ref_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 ref_clk = ~ref_clk;

    uart_rx_frame_if bus();

    uart_rx_frame #(
        .PARITY_ODD  (PARITY_ODD),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    bit cmp_en     = 1'b0;
    bit auto_ready = 1'b0;

    // ---------------- frame-level model ----------------
    logic [11:0] exp_q[$];
    int          m_cnt;
    logic        m_pend;
    logic [11:0] m_frame;
    logic        m_valid, m_perr, m_ferr, m_ovr, m_busy;
    logic [7:0]  m_data;
    logic        tick_in_done;

    always @(posedge ref_clk) begin
        if (reset) begin
            m_cnt        <= 0;
            m_pend       <= 1'b0;
            m_frame      <= '0;
            m_valid      <= 1'b0;
            m_data       <= 8'd0;
            m_perr       <= 1'b0;
            m_ferr       <= 1'b0;
            m_ovr        <= 1'b0;
            m_busy       <= 1'b0;
            tick_in_done <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_pend) begin
                m_pend <= 1'b0;
                if (!m_valid || bus.rx_ready) begin
                    m_valid <= 1'b1;
                    m_data  <= m_frame[8:1];
                    m_perr  <= (m_frame[9] != ((^m_frame[8:1]) ^ PARITY_ODD));
                    m_ferr  <= m_frame[0] | ~m_frame[10] | ~m_frame[11];
                    m_ovr   <= 1'b0;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && bus.rx_ready) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
            end
            if (bus.baud_tick) begin
                if (m_pend) tick_in_done <= 1'b1;
                if (m_cnt == FRAME_BAUDS - 1) begin
                    m_cnt   <= 0;
                    m_busy  <= 1'b0;
                    m_pend  <= 1'b1;
                    m_frame <= exp_q.pop_front();
                end else begin
                    m_cnt  <= m_cnt + 1;
                    m_busy <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cycle_compare();
        logic [12:0] got, want;
        got  = {bus.rx_valid, bus.rx_data, bus.parity_err, bus.frame_err, bus.overrun, bus.busy};
        want = {m_valid, m_data, m_perr, m_ferr, m_ovr, m_busy};
        compared++;
        if (got !== want || tick_in_done) begin
            mismatched++;
            $display("FAIL cycle t=%0t {valid,data,perr,ferr,ovr,busy} got=%b_%h_%b%b%b%b want=%b_%h_%b%b%b%b tick_in_done=%b",
                     $time, got[12], got[11:4], got[3], got[2], got[1], got[0],
                     want[12], want[11:4], want[3], want[2], want[1], want[0], tick_in_done);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(negedge ref_clk);
        if (cmp_en) cycle_compare();
        @(posedge ref_clk);
        #1;
        if (auto_ready) bus.rx_ready = ($urandom_range(0, 2) == 0);
    endtask

    function automatic logic [11:0] mk(input logic [7:0] d, input logic par,
                                       input logic st, input logic s1, input logic s2);
        return {s2, s1, par, d, st};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    // Sends the first n_ticks bits of frame f, with an rx glitch after every tick.
    task automatic send_frame(input logic [11:0] f, input int n_ticks, input bit done_ready);
        exp_q.push_back(f);
        for (int i = 0; i < n_ticks; i++) begin
            bus.rx = f[i];
            repeat ($urandom_range(3, 6)) step();
            bus.baud_tick = 1'b1;
            step();
            bus.baud_tick = 1'b0;
            if (i == 0)  chk("busy_after_tick0", 8'(bus.busy), 8'd1);
            if (i == 11) chk("busy_in_done", 8'(bus.busy), 8'd0);
            bus.rx = ~f[i];
            if (i == 11 && done_ready) bus.rx_ready = 1'b1;
            step();
            if (i == 11 && done_ready) bus.rx_ready = 1'b0;
        end
        bus.rx = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic ov);
        chk({name, "_data"}, bus.rx_data, d);
        chk({name, "_flags"}, {4'd0, bus.rx_valid, bus.parity_err, bus.frame_err, bus.overrun},
            {4'd0, v, pe, fe, ov});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        bus.rx        = 1'b1;
        bus.baud_tick = 1'b0;
        bus.rx_ready  = 1'b0;
        reset         = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 8'(bus.busy), 8'd0);
        reset = 1'b0;
        step();

        bus.rx_ready = 1'b1;
        send_frame(mk(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        chk_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(mk(8'h01, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        chk_out("par01", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(mk(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0), 12, 1'b0);
        chk_out("stop2_3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1), 12, 1'b0);
        chk_out("start00", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(mk(8'h7E, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        chk_out("align7e", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        bus.rx_ready = 1'b0;
        send_frame(mk(8'h11, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        send_frame(mk(8'h22, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        chk_out("overrun", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        chk_out("ovr_clear", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(mk(8'h11, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        send_frame(mk(8'h22, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b1);
        chk_out("accept_in_done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

        send_frame(mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1), 6, 1'b0);
        reset = 1'b1;
        step();
        chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_busy", 8'(bus.busy), 8'd0);
        reset = 1'b0;
        step();
        bus.rx_ready = 1'b1;
        send_frame(mk(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1), 12, 1'b0);
        chk_out("after_reset_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        auto_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            send_frame(mk(d, good_par(d) ^ ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 7) != 0)), 12, 1'b0);
            repeat ($urandom_range(0, 4)) step();
        end
        auto_ready   = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive deframer, directly downstream of the baud generator.
- Samples the synchronised Rx line on each mid-bit baud pulse and assembles the 12-bit frame: 1 start, 8 data (LSB first), 1 parity, 2 stop.
- Checks the start bit, parity and stop bits.
- Presents the byte and its error flags through a single-entry valid/ready holding register to the packet layer.

Parameters:
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- SYNC_STAGES, 2, number of flops in the rx synchroniser (minimum 2).

Ports:
- ref_clk  input  1  500 MHz reference clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- rx  input  1  asynchronous serial line; idle high.
- baud_tick  input  1  one-ref_clk pulse at each bit centre from the baud generator; exactly 12 pulses per frame.
- rx_data  output  8  received byte.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready.
- parity_err  output  1  parity mismatch for the held byte.
- frame_err  output  1  start bit sampled 1, or either stop bit sampled 0, for the held byte.
- overrun  output  1  at least one frame was dropped while the held byte waited.
- busy  output  1  frame in progress (tick count 1..11).

Behaviour:
- Reset values:
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - Synchroniser flops = 1, tick counter = 0, shift register = 0, state = IDLE.
- Synchronisation: rx passes through SYNC_STAGES flops to give rx_s. All sampling uses rx_s. The synchroniser delay (4 ns) is negligible against the 30.5 us bit.
- Tick counter: 4 bits, counts 0..11 and advances only on baud_tick. After the 12th tick (count 11) it wraps to 0.
- A bad start bit does not abort the frame. All 12 ticks are always consumed so the block stays aligned with the generator.
- State machine (a transition and its sample happen in the cycle baud_tick = 1):
  - IDLE: tick -> capture start = rx_s -> DATA; busy = 1.
  - DATA: ticks 1..8 -> shift rx_s into bit [n-1] (LSB first); after the 8th -> PARITY.
  - PARITY: tick 9 -> capture par = rx_s -> STOP1.
  - STOP1: tick 10 -> capture stop1 -> STOP2.
  - STOP2: tick 11 -> capture stop2 -> DONE.
  - DONE: single cycle with no tick required -> evaluate and load the holding register -> IDLE; busy = 0.
- Error evaluation:
  - Expected parity = XOR of the 8 data bits, XOR PARITY_ODD.
  - parity_err = (par != expected).
  - frame_err = start | ~stop1 | ~stop2.
  - The byte is delivered even when errored.
- Latency: rx_valid rises on the cycle after the tick-11 cycle, i.e. 1 ref_clk after the last stop sample.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready = 1; it drops on the following edge.
  - rx_data and the error flags are stable while rx_valid = 1.
- Overrun:
  - In DONE with rx_valid = 1 and rx_ready = 0: the new frame is discarded, held contents are unchanged, and overrun is set.
  - overrun is sticky and clears when the held byte is accepted.
- Simultaneous accept and DONE (rx_valid && rx_ready in the DONE cycle): old byte is accepted, new byte is loaded, rx_valid stays 1, overrun = 0.
- baud_tick during DONE cannot occur (ticks are 15259 cycles apart). The RTL does not need to handle it; the bench asserts it never happens.
- Reset mid-frame: everything returns to reset values at the next edge, including the holding register. The partial frame is lost.
- An rx glitch between ticks has no effect; only the tick-cycle sample matters.

Decomposition:
- Package uart_pkg holds:
  - BAUD_START = 1, BAUD_DATA = 8, BAUD_PARITY = 1, BAUD_STOP = 2, FRAME_BAUDS = 12.
  - State enum: IDLE, DATA, PARITY, STOP1, STOP2, DONE.
  - Parity helper function.
- Sub-module uart_sync: parameterised SYNC_STAGES flop chain with reset value 1; reused by other Rx-side blocks.

Test Plan:
- Frame 0xA5, parity 0, stops 1,1, PARITY_ODD = 0 -> rx_data = 0xA5, parity_err = 0, frame_err = 0. rx_valid rises 1 cycle after tick 11; busy is high from tick 0 through tick 11.
- Frame 0x01 with parity bit 0 (even parity expects 1) -> rx_data = 0x01, parity_err = 1, frame_err = 0.
- Frame 0x3C with stop2 = 0 -> frame_err = 1, rx_data = 0x3C. Start bit sampled 1 on frame 0x00 -> frame_err = 1, and the next frame 0x7E is received cleanly (alignment kept).
- rx_ready = 0, frames 0x11 then 0x22 -> rx_data stays 0x11 and overrun = 1. Pulse rx_ready -> rx_valid = 0 and overrun = 0 on the next edge.
- Hold 0x11, assert rx_ready exactly in the DONE cycle of frame 0x22 -> rx_data = 0x22, rx_valid = 1, overrun = 0.
- Assert reset after tick 5 of frame 0xFF -> all outputs 0, busy = 0. A fresh 12-tick frame 0x5A is then received with no errors.
